// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared types and constants for the memory port arbiter
package memory_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_e;

    localparam int WORD_SIZE = 32;
    localparam int BE_WIDTH  = WORD_SIZE / 8;

endpackage

// File: rtl/resp_buffer.sv
// rtl/resp_buffer.sv - one-entry valid/ready response register
module resp_buffer
    import memory_pkg::*;
#(
    parameter int W = WORD_SIZE
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         resp_ready,
    output logic         resp_valid,
    output logic [W-1:0] resp_data,
    output logic         can_accept
);

    // Full-and-draining counts as free so a new word can land on the same edge.
    assign can_accept = !resp_valid || resp_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else if (load) begin
            resp_valid <= 1'b1;
            resp_data  <= load_data;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - D-priority arbiter sharing one memory between fetch and load/store
module memory_port_arbiter
    import memory_pkg::*;
#(
    parameter int ADRESS_SIZE  = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   IReqValid,
    output logic                   IReqReady,
    input  logic [ADRESS_SIZE-1:0] IAdr,
    output logic                   IRespValid,
    input  logic                   IRespReady,
    output logic [WORD_SIZE-1:0]   IRespData,
    input  logic                   DReqValid,
    output logic                   DReqReady,
    input  logic                   DWrite,
    input  logic [BE_WIDTH-1:0]    DByteEn,
    input  logic [ADRESS_SIZE-1:0] DAdr,
    input  logic [WORD_SIZE-1:0]   DWriteData,
    output logic                   DRespValid,
    input  logic                   DRespReady,
    output logic [WORD_SIZE-1:0]   DRespData,
    output logic                   MemEn,
    output logic                   WriteEnable,
    output logic [BE_WIDTH-1:0]    ByteEn,
    output logic [ADRESS_SIZE-1:0] MemoryAdress,
    output logic [WORD_SIZE-1:0]   InputData,
    input  logic [WORD_SIZE-1:0]   MemData
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       i_can, d_can, i_elig, d_elig, starve_hit, d_store;
    logic [3:0] StarveCnt;
    grant_e     grant, LastGrant;

    assign i_elig     = IReqValid && i_can;
    assign d_elig     = DReqValid && d_can;
    assign starve_hit = (StarveCnt == LIMIT);

    // Grants are gated by reset so nothing in flight during reset is accepted.
    always_comb begin
        grant = GNT_NONE;
        if (reset_n) begin
            if (i_elig && d_elig)
                grant = starve_hit ? GNT_I : GNT_D;
            else if (d_elig)
                grant = GNT_D;
            else if (i_elig)
                grant = GNT_I;
        end
    end

    assign IReqReady    = (grant == GNT_I);
    assign DReqReady    = (grant == GNT_D);
    assign d_store      = DReqReady && DWrite;

    assign MemEn        = IReqReady || DReqReady;
    assign WriteEnable  = d_store;
    assign ByteEn       = d_store ? DByteEn : '0;
    assign MemoryAdress = DReqReady ? DAdr : IAdr;
    assign InputData    = d_store ? DWriteData : '0;

    resp_buffer #(.W(WORD_SIZE)) u_ibuf (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (IReqReady),
        .load_data  (MemData),
        .resp_ready (IRespReady),
        .resp_valid (IRespValid),
        .resp_data  (IRespData),
        .can_accept (i_can)
    );

    resp_buffer #(.W(WORD_SIZE)) u_dbuf (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (DReqReady),
        .load_data  (DWrite ? '0 : MemData),
        .resp_ready (DRespReady),
        .resp_valid (DRespValid),
        .resp_data  (DRespData),
        .can_accept (d_can)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            StarveCnt <= 4'd0;
            LastGrant <= GNT_NONE;
        end else begin
            LastGrant <= grant;
            if (!i_elig || IReqReady)
                StarveCnt <= 4'd0;
            else if (DReqReady && !starve_hit)
                StarveCnt <= StarveCnt + 4'd1;
        end
    end

    a_one_grant: assert property (@(posedge clk) disable iff (!reset_n)
        !(IReqReady && DReqReady));
    a_i_win_clears: assert property (@(posedge clk) disable iff (!reset_n)
        (LastGrant == GNT_I) |-> (StarveCnt == 4'd0));
    a_starve_forces_i: assert property (@(posedge clk) disable iff (!reset_n)
        (i_elig && starve_hit) |-> IReqReady);

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - self-checking bench for memory_port_arbiter
module tb_memory_port_arbiter;

    localparam int AW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          IReqValid, IReqReady, IRespValid, IRespReady;
    logic [AW-1:0] IAdr;
    logic [31:0]   IRespData;
    logic          DReqValid, DReqReady, DWrite, DRespValid, DRespReady;
    logic [3:0]    DByteEn;
    logic [AW-1:0] DAdr;
    logic [31:0]   DWriteData, DRespData;
    logic          MemEn, WriteEnable;
    logic [3:0]    ByteEn;
    logic [AW-1:0] MemoryAdress;
    logic [31:0]   InputData, MemData;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_port_arbiter #(.ADRESS_SIZE(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .IReqValid(IReqValid), .IReqReady(IReqReady), .IAdr(IAdr),
        .IRespValid(IRespValid), .IRespReady(IRespReady), .IRespData(IRespData),
        .DReqValid(DReqValid), .DReqReady(DReqReady), .DWrite(DWrite),
        .DByteEn(DByteEn), .DAdr(DAdr), .DWriteData(DWriteData),
        .DRespValid(DRespValid), .DRespReady(DRespReady), .DRespData(DRespData),
        .MemEn(MemEn), .WriteEnable(WriteEnable), .ByteEn(ByteEn),
        .MemoryAdress(MemoryAdress), .InputData(InputData), .MemData(MemData)
    );

    // Environment memory: combinational read, byte-lane write on the clock.
    logic [31:0] mem [0:63];
    assign MemData = mem[MemoryAdress[7:2]];
    always @(posedge clk)
        if (MemEn && WriteEnable)
            for (int b = 0; b < 4; b++)
                if (ByteEn[b]) mem[MemoryAdress[7:2]][8*b +: 8] <= InputData[8*b +: 8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffer contents, starvation age and its own memory image.
    logic [31:0] m_mem [0:63];
    bit          m_ivalid, m_dvalid;
    logic [31:0] m_idata, m_ddata;
    int          m_starve;

    function automatic int exp_grant();
        bit i_ok, d_ok;
        i_ok = IReqValid && (!m_ivalid || IRespReady);
        d_ok = DReqValid && (!m_dvalid || DRespReady);
        if (!reset_n) return 0;
        if (i_ok && d_ok) return (m_starve >= LIMIT) ? 1 : 2;
        if (d_ok) return 2;
        if (i_ok) return 1;
        return 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ivalid = 0; m_dvalid = 0; m_idata = 0; m_ddata = 0; m_starve = 0;
        end else begin
            int g;
            bit i_ok;
            g = exp_grant();
            i_ok = IReqValid && (!m_ivalid || IRespReady);
            if (g == 1) begin
                m_ivalid = 1; m_idata = m_mem[IAdr[7:2]];
            end else if (IRespReady) m_ivalid = 0;
            if (g == 2) begin
                m_dvalid = 1;
                if (DWrite) begin
                    m_ddata = 0;
                    for (int b = 0; b < 4; b++)
                        if (DByteEn[b]) m_mem[DAdr[7:2]][8*b +: 8] = DWriteData[8*b +: 8];
                end else m_ddata = m_mem[DAdr[7:2]];
            end else if (DRespReady) m_dvalid = 0;
            if (!i_ok || g == 1) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            int g;
            bit st;
            g  = exp_grant();
            st = (g == 2) && DWrite;
            check("IReqReady", 32'(IReqReady), 32'(g == 1));
            check("DReqReady", 32'(DReqReady), 32'(g == 2));
            check("MemEn", 32'(MemEn), 32'(g != 0));
            check("WriteEnable", 32'(WriteEnable), 32'(st));
            check("ByteEn", 32'(ByteEn), st ? 32'(DByteEn) : 32'd0);
            if (g != 0) check("MemoryAdress", MemoryAdress, (g == 2) ? DAdr : IAdr);
            if (st) check("InputData", InputData, DWriteData);
            check("IRespValid", 32'(IRespValid), 32'(m_ivalid));
            check("DRespValid", 32'(DRespValid), 32'(m_dvalid));
            if (m_ivalid) check("IRespData", IRespData, m_idata);
            if (m_dvalid) check("DRespData", DRespData, m_ddata);
            check("StarveCnt", 32'(dut.StarveCnt), 32'(m_starve));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        string seq;
        reset_n = 0;
        IReqValid = 0; IAdr = 0; IRespReady = 1;
        DReqValid = 0; DWrite = 0; DByteEn = 0; DAdr = 0; DWriteData = 0; DRespReady = 1;
        for (int k = 0; k < 64; k++) begin
            mem[k]   = 32'h0100_0000 * k + 32'h5A;
            m_mem[k] = 32'h0100_0000 * k + 32'h5A;
        end
        mem[4] = 32'hDEADBEEF; m_mem[4] = 32'hDEADBEEF;
        mem[8] = 32'hAABBCCDD; m_mem[8] = 32'hAABBCCDD;

        step(); step();
        check("rst_IRespValid", 32'(IRespValid), 0);
        check("rst_DRespValid", 32'(DRespValid), 0);
        check("rst_IRespData", IRespData, 0);
        check("rst_DRespData", DRespData, 0);
        check("rst_MemEn", 32'(MemEn), 0);
        check("rst_WriteEnable", 32'(WriteEnable), 0);
        reset_n = 1;

        // Single fetch: accepted in cycle 0, response visible in cycle 1.
        IReqValid = 1; IAdr = 32'h10;
        #3 check("t1_IReqReady", 32'(IReqReady), 1);
        step();
        IReqValid = 0;
        check("t1_IRespValid", 32'(IRespValid), 1);
        check("t1_IRespData", IRespData, 32'hDEADBEEF);
        step();

        // Both ports hammering: starvation bound forces every fifth grant to I.
        IReqValid = 1; IAdr = 32'h14; DReqValid = 1; DAdr = 32'h18;
        seq = "";
        for (int c = 0; c < 10; c++) begin
            #3 seq = {seq, IReqReady ? "I" : (DReqReady ? "D" : "-")};
            step();
            IAdr = IAdr + 4; DAdr = DAdr + 4;
        end
        checks++;
        if (seq != "DDDDIDDDDI") begin
            failures++;
            $display("FAIL t2_grant_seq: got %s expected DDDDIDDDDI", seq);
        end
        IReqValid = 0; DReqValid = 0;
        step();

        // Partial store then load back over the original word.
        DReqValid = 1; DWrite = 1; DAdr = 32'h20; DByteEn = 4'b0101; DWriteData = 32'h11223344;
        step();
        check("t3_store_ack_valid", 32'(DRespValid), 1);
        check("t3_store_ack_data", DRespData, 0);
        DWrite = 0; DByteEn = 0;
        step();
        DReqValid = 0;
        check("t3_load_data", DRespData, 32'hAA22CC44);
        step();

        // I buffer held full: D served every cycle, I never ages.
        IReqValid = 1; IAdr = 32'h10; IRespReady = 0;
        step();
        DReqValid = 1; DAdr = 32'h24;
        for (int c = 0; c < 5; c++) begin
            #3;
            check("t4_IReqReady", 32'(IReqReady), 0);
            check("t4_DReqReady", 32'(DReqReady), 1);
            check("t4_StarveCnt", 32'(dut.StarveCnt), 0);
            step();
        end
        IReqValid = 0; DReqValid = 0; IRespReady = 1;
        step();

        // Fill both buffers, then drop reset during a granted store.
        IRespReady = 0; DRespReady = 0; IReqValid = 1; DReqValid = 1; DAdr = 32'h28;
        step(); step();
        IReqValid = 0; DRespReady = 1;
        DWrite = 1; DAdr = 32'h20; DByteEn = 4'hF; DWriteData = 32'hFFFFFFFF;
        #1 check("t5_pre_DReqReady", 32'(DReqReady), 1);
        #1 reset_n = 0;
        #1;
        check("t5_MemEn", 32'(MemEn), 0);
        check("t5_WriteEnable", 32'(WriteEnable), 0);
        check("t5_IRespValid", 32'(IRespValid), 0);
        check("t5_DRespValid", 32'(DRespValid), 0);
        step();
        check("t5_mem_unchanged", mem[8], 32'hAA22CC44);
        DReqValid = 0; DWrite = 0; IRespReady = 1;
        reset_n = 1;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares one single-port word memory (`vectorStorage`: `MemEn`/`WriteEnable`/`ByteEn` interface, combinational read, write-while-enabled) between the instruction-fetch port (I) and the load/store port (D) of the pipelined core. Each cycle it grants at most one requester and drives the memory control signals. It registers the read data into a per-port one-entry response buffer with valid/ready handshakes. It applies fixed D-priority with a starvation bound for I.

## Interface
Parameters:
- `ADRESS_SIZE`, 32, byte-address width on all ports.
- `STARVE_LIMIT`, 4, consecutive cycles I may be refused while pending before I is forced to win; legal range 1–15.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `IReqValid`  in  1  I read request.
- `IReqReady`  out  1  I request accepted this cycle.
- `IAdr`  in  `ADRESS_SIZE`  I byte address.
- `IRespValid`  out  1  I response buffer full.
- `IRespReady`  in  1  I consumer takes the response.
- `IRespData`  out  32  I read word.
- `DReqValid`  in  1  D request.
- `DReqReady`  out  1  D request accepted this cycle.
- `DWrite`  in  1  1 = store, 0 = load.
- `DByteEn`  in  4  store byte lanes.
- `DAdr`  in  `ADRESS_SIZE`  D byte address.
- `DWriteData`  in  32  store data.
- `DRespValid`  out  1  D response buffer full.
- `DRespReady`  in  1  D consumer takes the response.
- `DRespData`  out  32  D load word; 0 for store acknowledgements.
- `MemEn`, `WriteEnable`  out  1 each  memory enables.
- `ByteEn`  out  4  memory byte enables.
- `MemoryAdress`  out  `ADRESS_SIZE`  memory byte address.
- `InputData`  out  32  memory write data.
- `MemData`  in  32  memory read data (combinational).

## Operation
- Port X is eligible when `XReqValid` and its response buffer can accept a word. A buffer can accept when it is empty, or full with `XRespReady`=1 this cycle (same-cycle drain and refill).
- Grant rules:
  - D wins when both are eligible, unless `StarveCnt == STARVE_LIMIT`; then I wins.
  - If only one port is eligible, it wins.
  - `XReqReady` = grant to X, combinational.
- On a grant, the memory outputs are driven from the winning port:
  - `MemEn`=1 and `MemoryAdress` = winner's address.
  - D store: `WriteEnable`=1, `ByteEn`=`DByteEn`, `InputData`=`DWriteData`.
  - Otherwise `WriteEnable`=0 and `ByteEn`=0.
- With no grant, `MemEn`=`WriteEnable`=0.
- All memory enables are gated by `reset_n`, so the latch memory is never written during reset.
- Response capture at the edge ending a granted cycle:
  - The winner's buffer loads `MemData` (D store: loads 0) and its valid bit sets.
  - A buffer with valid=1 and ready=1 and no new grant clears.
- Starvation counter `StarveCnt` (4 bits):
  - Increments, saturating at `STARVE_LIMIT`, when I is eligible and D wins.
  - Clears whenever I wins or I is not eligible.
- `LastGrant` state: NONE/I/D, records the previous cycle's winner. It is debug-visible and also used for the grant-order assertions.
- Addresses pass through unmodified; word selection (`>>2`) stays in the memory. Misaligned addresses are the requester's responsibility.

## Timing
- Request accepted in cycle N → response valid from cycle N+1; it holds until the handshake completes.
- Throughput is one access per cycle per winner with `RespReady` held high.
- Reset values: all `*RespValid`=0, `*RespData`=0, `StarveCnt`=0, `LastGrant`=NONE, `MemEn`=`WriteEnable`=0.
- Reset asserted mid-transfer: buffered responses are discarded immediately (asynchronously). A request in flight that cycle produces no response and no write.
- Boundary cases:
  - Simultaneous eligible I and D with `StarveCnt < STARVE_LIMIT`: D granted.
  - At the limit: I granted and the counter clears.
  - Full buffer with `RespReady`=0: that port's `ReqReady`=0; the other port proceeds.

## Structure
- Shared package `memory_pkg`: `grant_e` enum {GNT_NONE, GNT_I, GNT_D}, `WORD_SIZE`=32, byte-enable width constant.
- One sub-module `resp_buffer`: one-entry valid/ready register with load, drain and simultaneous load+drain. It is instantiated twice, for I and D.

## Test plan
- Reset then I read of 0x10 with memory word 0xDEADBEEF → `IReqReady`=1 in cycle 0; `IRespValid`=1, `IRespData`=0xDEADBEEF in cycle 1.
- Both ports request every cycle, `STARVE_LIMIT`=4, all `RespReady`=1 → grant sequence D,D,D,D,I,D,D,D,D,I…
- D store 0x11223344 to 0x20 with `DByteEn`=0101, then D load 0x20 over an initial 0xAABBCCDD → load returns 0xAA22CC44; store ack has `DRespData`=0.
- I buffer full with `IRespReady`=0 while I and D request → `IReqReady`=0, D served each cycle, `StarveCnt` stays 0.
- `reset_n` dropped during a granted store → `MemEn`=`WriteEnable`=0 immediately, memory word unchanged, both `RespValid`=0.
